// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory port between the pipeline memory stage (P) and a
//   debug/loader master (D). P has fixed priority; D is forced through after
//   STARVE_LIMIT consecutive refused cycles. Read data (one-cycle latency)
//   is routed back to whichever requester issued the read.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   p_req/p_addr/p_we/p_wdata       P request (we==0 means read)
//   p_gnt                           P accepted this cycle (combinational)
//   p_rvalid/p_rdata                P read response, one cycle after grant
//   d_*                             same set for requester D
//   mem_addr/mem_we/mem_wdata       memory request from the granted master
//   mem_rdata                       memory read data, valid cycle after addr
//   stall_req                       P refused this cycle
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p_req,
  input  logic [ADDR_WIDTH-1:0]   p_addr,
  input  logic [DATA_WIDTH/8-1:0] p_we,
  input  logic [DATA_WIDTH-1:0]   p_wdata,
  output logic                    p_gnt,
  output logic                    p_rvalid,
  output logic [DATA_WIDTH-1:0]   p_rdata,
  input  logic                    d_req,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH/8-1:0] d_we,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_req
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e     rd_owner_q, rd_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       d_force;
  logic       p_gnt_w, d_gnt_w;

  // Arbitration. Grants are held off while reset is asserted so nothing
  // reaches memory before the first clean edge.
  always_comb begin
    d_force = d_req && (starve_cnt_q >= STARVE_LIM);
    p_gnt_w = 1'b0;
    d_gnt_w = 1'b0;
    if (!rst) begin
      if (d_force) begin
        d_gnt_w = 1'b1;
      end else if (p_req) begin
        p_gnt_w = 1'b1;
      end else if (d_req) begin
        d_gnt_w = 1'b1;
      end
    end
  end

  assign p_gnt     = p_gnt_w;
  assign d_gnt     = d_gnt_w;
  assign stall_req = p_req && !rst && !p_gnt_w;

  // Address/data default to P when idle; write enables only ever come from
  // the grantee, so a refused write cannot leak into memory.
  assign mem_addr  = d_gnt_w ? d_addr  : p_addr;
  assign mem_wdata = d_gnt_w ? d_wdata : p_wdata;
  assign mem_we    = d_gnt_w ? d_we : (p_gnt_w ? p_we : '0);

  // Next-state: starvation counter and read-owner tracking.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rd_owner_d   = OWN_NONE;

    // Any gap in D's request or a D grant restarts the count (no carry-over).
    if (!d_req || d_gnt_w) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    if (p_gnt_w && (p_we == '0)) begin
      rd_owner_d = OWN_P;
    end else if (d_gnt_w && (d_we == '0)) begin
      rd_owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Response routing: the non-owner sees zero data.
  assign p_rvalid = (rd_owner_q == OWN_P);
  assign d_rvalid = (rd_owner_q == OWN_D);
  assign p_rdata  = p_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, d_req;
  logic [AW-1:0] p_addr, d_addr;
  logic [BW-1:0] p_we, d_we;
  logic [DW-1:0] p_wdata, d_wdata;
  logic          p_gnt, d_gnt, p_rvalid, d_rvalid, stall_req;
  logic [DW-1:0] p_rdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_addr(p_addr), .p_we(p_we), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_req(stall_req)
  );

  // Data memory seen by the DUT: byte-lane writes, one-cycle registered read.
  logic [DW-1:0] tb_mem  [0:DEPTH-1];
  // Golden memory contents as the reference model believes them to be.
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    mem_rdata <= tb_mem[mem_addr];
    for (int b = 0; b < BW; b++)
      if (mem_we[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  int total = 0;
  int bad   = 0;

  // Reference model: consecutive-refusal count for D, who owns the pending
  // read response (0 none, 1 P, 2 D) and the data that response must carry.
  int            starve_m;
  int            owner_m;
  logic [DW-1:0] rdata_m;
  logic          e_p_gnt, e_d_gnt, e_stall;
  logic [BW-1:0] e_we;

  task automatic model_reset();
    starve_m = 0;
    owner_m  = 0;
    rdata_m  = '0;
  endtask

  task automatic predict();
    logic force_d;
    force_d = d_req && (starve_m >= LIMIT);
    e_d_gnt = force_d || (!p_req && d_req);
    e_p_gnt = p_req && !force_d;
    e_stall = p_req && !e_p_gnt;
    e_we    = e_p_gnt ? p_we : (e_d_gnt ? d_we : '0);
  endtask

  task automatic apply_write(input logic [AW-1:0] a, input logic [BW-1:0] we,
                             input logic [DW-1:0] wd);
    for (int b = 0; b < BW; b++)
      if (we[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Clock one cycle and advance the model using the inputs present at the edge.
  task automatic step();
    predict();
    @(posedge clk);
    owner_m = 0;
    if (e_p_gnt && p_we == '0) begin owner_m = 1; rdata_m = ref_mem[p_addr]; end
    if (e_d_gnt && d_we == '0) begin owner_m = 2; rdata_m = ref_mem[d_addr]; end
    if (e_p_gnt && p_we != '0) apply_write(p_addr, p_we, p_wdata);
    if (e_d_gnt && d_we != '0) apply_write(d_addr, d_we, d_wdata);
    if (d_req && !e_d_gnt) starve_m = (starve_m < 15) ? starve_m + 1 : 15;
    else                   starve_m = 0;
    #1;
  endtask

  task automatic idle();
    p_req = 1'b0; p_we = '0; p_addr = '0; p_wdata = '0;
    d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    // Outputs while reset is held with both masters requesting.
    p_req = 1'b1; d_req = 1'b1;
    #1;
    total++; if ({p_gnt, d_gnt, stall_req} !== 3'b000) begin bad++;
      $display("FAIL rst_hold_gnt: got gnt/stall=%b want 000", {p_gnt, d_gnt, stall_req}); end
    total++; if (mem_we !== '0) begin bad++;
      $display("FAIL rst_hold_we: got %h want 0", mem_we); end
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    model_reset();
    step();
    // Granted read at 0x10, then reset asserted mid-cycle.
    p_req = 1'b1; p_addr = 14'h10; p_we = '0;
    @(negedge clk);
    total++; if (p_gnt !== 1'b1) begin bad++;
      $display("FAIL rst_pre_gnt: got %b want 1", p_gnt); end
    #1 rst = 1'b1;
    #1;
    $display("txn reset asserted during read of 0x10");
    total++; if ({p_gnt, d_gnt, stall_req, p_rvalid, d_rvalid} !== 5'b0) begin bad++;
      $display("FAIL rst_async_ctl: got %b want 00000", {p_gnt, d_gnt, stall_req, p_rvalid, d_rvalid}); end
    total++; if (mem_we !== '0 || p_rdata !== '0 || d_rdata !== '0) begin bad++;
      $display("FAIL rst_async_data: got we=%h prd=%h drd=%h want 0", mem_we, p_rdata, d_rdata); end
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++; if (p_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++;
      $display("FAIL rst_no_rvalid: got p=%b d=%b want 0 0", p_rvalid, d_rvalid); end
    step();
  endtask

  task automatic test_p_rw();
    logic [DW-1:0] want [2];
    logic [BW-1:0] wr_we [2];
    logic [DW-1:0] wr_dt [2];
    want[0] = 32'hDEADBEEF; wr_we[0] = 4'b1111; wr_dt[0] = 32'hDEADBEEF;
    want[1] = 32'hDEADBEAB; wr_we[1] = 4'b0001; wr_dt[1] = 32'h000000AB;
    for (int i = 0; i < 2; i++) begin
      p_req = 1'b1; p_addr = 14'h20; p_we = wr_we[i]; p_wdata = wr_dt[i];
      @(negedge clk);
      $display("txn P write 0x20 we=%b data=%h", p_we, p_wdata);
      total++; if (p_gnt !== 1'b1 || mem_we !== wr_we[i]) begin bad++;
        $display("FAIL p_wr_gnt: got gnt=%b we=%b want 1 %b", p_gnt, mem_we, wr_we[i]); end
      step();
      p_we = '0;
      @(negedge clk);
      total++; if (p_gnt !== 1'b1 || p_rvalid !== 1'b0) begin bad++;
        $display("FAIL p_rd_gnt: got gnt=%b rvalid=%b want 1 0", p_gnt, p_rvalid); end
      step();
      idle();
      @(negedge clk);
      $display("txn P read 0x20 -> %h", p_rdata);
      total++; if (p_rvalid !== 1'b1 || p_rdata !== want[i]) begin bad++;
        $display("FAIL p_rd_data: got v=%b d=%h want 1 %h", p_rvalid, p_rdata, want[i]); end
      step();
    end
  endtask

  task automatic test_contention();
    logic exp_d;
    idle();
    step();
    for (int k = 0; k < 10; k++) begin
      p_req = 1'b1; d_req = 1'b1; p_we = '0; d_we = '0;
      if (k == 0 || p_gnt) p_addr = 14'($urandom_range(0, 15));
      if (k == 0 || d_gnt) d_addr = 14'($urandom_range(0, 15));
      @(negedge clk);
      exp_d = (k % 5 == 4);
      $display("txn contention cycle %0d p_gnt=%b d_gnt=%b", k, p_gnt, d_gnt);
      total++; if (d_gnt !== exp_d || p_gnt !== !exp_d || stall_req !== exp_d) begin bad++;
        $display("FAIL contention_%0d: got p=%b d=%b stall=%b want %b %b %b",
                 k, p_gnt, d_gnt, stall_req, !exp_d, exp_d, exp_d); end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    p_req = 1'b1; p_addr = 14'h1;
    @(negedge clk);
    total++; if (p_gnt !== 1'b1) begin bad++;
      $display("FAIL b2b_p_gnt: got %b want 1", p_gnt); end
    step();
    idle();
    d_req = 1'b1; d_addr = 14'h2;
    @(negedge clk);
    $display("txn b2b P read 0x1 -> %h", p_rdata);
    total++; if (d_gnt !== 1'b1 || p_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin bad++;
      $display("FAIL b2b_c1_ctl: got dg=%b pv=%b dv=%b want 1 1 0", d_gnt, p_rvalid, d_rvalid); end
    total++; if (p_rdata !== ref_mem[1] || d_rdata !== '0) begin bad++;
      $display("FAIL b2b_c1_data: got p=%h d=%h want %h 0", p_rdata, d_rdata, ref_mem[1]); end
    step();
    idle();
    @(negedge clk);
    $display("txn b2b D read 0x2 -> %h", d_rdata);
    total++; if (d_rvalid !== 1'b1 || p_rvalid !== 1'b0) begin bad++;
      $display("FAIL b2b_c2_ctl: got dv=%b pv=%b want 1 0", d_rvalid, p_rvalid); end
    total++; if (d_rdata !== ref_mem[2] || p_rdata !== '0) begin bad++;
      $display("FAIL b2b_c2_data: got d=%h p=%h want %h 0", d_rdata, p_rdata, ref_mem[2]); end
    step();
  endtask

  task automatic test_refused_write();
    logic [DW-1:0] old;
    idle();
    old = ref_mem[14'h30];
    d_req = 1'b1; d_addr = 14'h30; d_we = 4'b1111; d_wdata = 32'h12345678;
    p_req = 1'b1; p_addr = 14'h31; p_we = '0;
    @(negedge clk);
    total++; if (d_gnt !== 1'b0 || p_gnt !== 1'b1 || mem_we !== '0) begin bad++;
      $display("FAIL refwr_block: got dg=%b pg=%b we=%b want 0 1 0", d_gnt, p_gnt, mem_we); end
    step();
    p_req = 1'b0;
    @(negedge clk);
    $display("txn refused D write 0x30, P read 0x31 -> %h", p_rdata);
    total++; if (tb_mem[14'h30] !== old) begin bad++;
      $display("FAIL refwr_unchanged: got %h want %h", tb_mem[14'h30], old); end
    total++; if (p_rvalid !== 1'b1 || p_rdata !== ref_mem[14'h31]) begin bad++;
      $display("FAIL refwr_p_data: got v=%b d=%h want 1 %h", p_rvalid, p_rdata, ref_mem[14'h31]); end
    total++; if (d_gnt !== 1'b1 || mem_we !== 4'b1111) begin bad++;
      $display("FAIL refwr_d_gnt: got g=%b we=%b want 1 1111", d_gnt, mem_we); end
    step();
    idle();
    @(negedge clk);
    total++; if (tb_mem[14'h30] !== 32'h12345678 || d_rvalid !== 1'b0) begin bad++;
      $display("FAIL refwr_done: got mem=%h dv=%b want 12345678 0", tb_mem[14'h30], d_rvalid); end
    step();
  endtask

  task automatic test_starve_reset();
    logic [8:0] dreq_pat;
    logic [8:0] dgnt_pat;
    dreq_pat = 9'b111110111;
    dgnt_pat = 9'b100000000;
    idle();
    step();
    for (int k = 0; k < 9; k++) begin
      p_req = 1'b1; p_we = '0; p_addr = 14'(k);
      d_req = dreq_pat[k]; d_we = '0; d_addr = 14'h5;
      @(negedge clk);
      $display("txn starve cycle %0d d_req=%b d_gnt=%b", k, d_req, d_gnt);
      total++; if (d_gnt !== dgnt_pat[k] || stall_req !== dgnt_pat[k]) begin bad++;
        $display("FAIL starve_%0d: got dg=%b stall=%b want %b %b",
                 k, d_gnt, stall_req, dgnt_pat[k], dgnt_pat[k]); end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_random();
    logic p_was_gnt, d_was_gnt;
    p_was_gnt = 1'b1; d_was_gnt = 1'b1;
    idle();
    for (int n = 0; n < 300; n++) begin
      if (!p_req || p_was_gnt) begin
        p_req   = ($urandom_range(0, 3) != 0);
        p_addr  = 14'($urandom_range(0, 15));
        p_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        p_wdata = $urandom;
      end
      if (!d_req || d_was_gnt) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_addr  = 14'($urandom_range(0, 15));
        d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        d_wdata = $urandom;
      end
      @(negedge clk);
      predict();
      if (p_gnt || d_gnt)
        $display("txn rnd %0d %s addr=%h we=%b", n, p_gnt ? "P" : "D", mem_addr, mem_we);
      total++; if (p_gnt !== e_p_gnt || d_gnt !== e_d_gnt || stall_req !== e_stall) begin bad++;
        $display("FAIL rnd_gnt_%0d: got p=%b d=%b s=%b want %b %b %b",
                 n, p_gnt, d_gnt, stall_req, e_p_gnt, e_d_gnt, e_stall); end
      total++; if (mem_we !== e_we) begin bad++;
        $display("FAIL rnd_we_%0d: got %b want %b", n, mem_we, e_we); end
      total++; if (p_rvalid !== (owner_m == 1) || d_rvalid !== (owner_m == 2)) begin bad++;
        $display("FAIL rnd_rvalid_%0d: got p=%b d=%b want owner %0d", n, p_rvalid, d_rvalid, owner_m); end
      total++; if (p_rdata !== ((owner_m == 1) ? rdata_m : '0) ||
                   d_rdata !== ((owner_m == 2) ? rdata_m : '0)) begin bad++;
        $display("FAIL rnd_rdata_%0d: got p=%h d=%h owner=%0d want %h", n, p_rdata, d_rdata, owner_m, rdata_m); end
      step();
      p_was_gnt = e_p_gnt;
      d_was_gnt = e_d_gnt;
    end
    idle();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = (i * 32'h01000193) ^ 32'hA5A50000;
      ref_mem[i] = (i * 32'h01000193) ^ 32'hA5A50000;
    end
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    test_reset();
    test_p_rw();
    test_contention();
    test_back_to_back();
    test_refused_write();
    test_starve_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between two requesters: the pipeline memory-access stage (requester P) and a debug/loader master (requester D). It sits between those masters and the data memory. It grants at most one access per cycle, with P having fixed priority and an anti-starvation override for D. It routes the one-cycle-latency read data back to whichever requester issued the read, and raises a stall request to the pipeline controller whenever P is refused.

## Interface
- ADDR_WIDTH, 14: word (line) address width.
- DATA_WIDTH, 32: data width; byte enables are DATA_WIDTH/8 bits.
- STARVE_LIMIT, 4: consecutive refused cycles of D before D is forced to win; legal range 1..15.

- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- p_req  in  1  P requests an access this cycle.
- p_addr  in  ADDR_WIDTH  P word address.
- p_we  in  DATA_WIDTH/8  P byte write enables; all-zero means read.
- p_wdata  in  DATA_WIDTH  P write data, already byte-lane aligned.
- p_gnt  out  1  P access accepted this cycle (combinational).
- p_rvalid  out  1  p_rdata is valid (registered).
- p_rdata  out  DATA_WIDTH  P read data.
- d_req, d_addr, d_we, d_wdata, d_gnt, d_rvalid, d_rdata: same as the P signals, for requester D.
- mem_addr  out  ADDR_WIDTH  address to data memory.
- mem_we  out  DATA_WIDTH/8  byte write enables to data memory.
- mem_wdata  out  DATA_WIDTH  write data to data memory.
- mem_rdata  in  DATA_WIDTH  read data from data memory, valid the cycle after the address.
- stall_req  out  1  P refused this cycle; tells the controller to stall the pipeline.

## Operation
- Request/grant handshake: a requester holds req, addr, we and wdata stable until it sees gnt=1 in the same cycle. An access completes in the cycle gnt=1.
- Arbitration, evaluated every cycle:
  - d_force = d_req && (starve_cnt >= STARVE_LIMIT).
  - If d_force: grant D.
  - Else if p_req: grant P.
  - Else if d_req: grant D.
  - Else: no grant.
- Memory port:
  - mem_addr, mem_we and mem_wdata come from the granted requester.
  - With no grant: mem_we = 0 and mem_addr = p_addr.
  - A refused requester's we must never reach mem_we.
- stall_req = p_req && !p_gnt.
- starve_cnt (4-bit register):
  - Clears when d_req=0 or d_gnt=1.
  - Increments when d_req=1 and d_gnt=0.
  - Saturates at 15.
- Read tracking:
  - A granted access with we==0 is a read.
  - rd_owner register: NONE, P or D. It is loaded with the grantee on a granted read and with NONE otherwise.
- Response routing:
  - p_rvalid = (rd_owner==P) and d_rvalid = (rd_owner==D).
  - p_rdata = mem_rdata when p_rvalid, else 0; d_rdata likewise.
- A granted write produces no rvalid.
- Reads are back-to-back capable: grants in consecutive cycles yield rvalids in consecutive cycles. Ownership can switch every cycle.

## Timing
- Reset values while rst=1, applied immediately (asynchronous):
  - p_gnt, d_gnt, mem_we and stall_req = 0; grants are gated off during reset.
  - starve_cnt = 0, rd_owner = NONE, p_rvalid and d_rvalid = 0, rdata outputs = 0.
- Grant latency: 0 cycles, combinational from req and starve_cnt.
- Read data latency: exactly 1 cycle after the grant cycle.
- Reset asserted mid-operation: a read granted in the cycle before reset produces no rvalid. The first grant after reset is on the first edge with rst=0.
- Simultaneous p_req and d_req with starve_cnt < STARVE_LIMIT: P wins and starve_cnt increments.
- After STARVE_LIMIT consecutive refusals, D wins on the next cycle. In that cycle p_gnt=0 and stall_req=1, then starve_cnt clears.
- D deasserting d_req before its grant clears starve_cnt; there is no credit carry-over.
- rd_owner updates on every edge. It is never held, because the pipeline stall does not stall this block.

## Test plan
- Reset: assert rst asynchronously mid-cycle during a granted read at addr 0x10. All outputs go to 0 immediately, and no rvalid follows after rst deasserts.
- P-only read/write:
  - Write 0xDEADBEEF to addr 0x20 with we=4'b1111, then read 0x20. p_gnt=1 both cycles; p_rvalid=1 only the cycle after the read, with p_rdata=0xDEADBEEF.
  - Write 0x000000AB to addr 0x20 with we=4'b0001 (byte lane 0 only), then read 0x20. p_rdata=0xDEADBEAB, confirming only lane 0 was written.
- Contention: hold p_req and d_req every cycle with STARVE_LIMIT=4. The grants follow P,P,P,P,D,P,P,P,P,D,…, and stall_req=1 exactly on the D cycles.
- Back-to-back alternating reads, P at 0x1 then D at 0x2 in consecutive cycles:
  - p_rvalid then d_rvalid in consecutive cycles, each carrying its own data.
  - The non-owner's rdata is 0.
- Refused write: d_req with d_we=4'b1111 at addr 0x30, refused in favour of a P read of 0x31. mem_we stays 0 that cycle, and memory at 0x30 is unchanged until D is granted.
- Starvation reset: D is refused 3 cycles, drops d_req for 1 cycle, then re-requests. D needs 4 further refusals before it is forced to win.
